// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one dmem port between the CPU and the display scanner.
// CPU has priority; a starved video request gets exactly one forced grant.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [11:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        cpu_wren,
    output logic        cpu_stall,
    output logic [31:0] cpu_q,
    input  logic        vid_req,
    input  logic [11:0] vid_address,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    output logic [31:0] vid_q,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL,
        FORCE
    } mode_t;

    mode_t       r_mode;
    logic [2:0]  r_starve_cnt;
    logic        r_vid_rvalid;
    logic        w_vid_gnt;
    logic        w_starved;
    logic        w_force_next;
    logic [2:0]  w_cnt_inc;

    always_comb begin
        w_vid_gnt = 1'b0;
        if (!reset) begin
            // A forced cycle still yields to a video request that went away.
            if (r_mode == FORCE) w_vid_gnt = vid_req;
            else                 w_vid_gnt = vid_req && !cpu_req;
        end
        w_starved    = vid_req && !w_vid_gnt;
        w_cnt_inc    = (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 3'd1;
        w_force_next = w_starved && (({1'b0, r_starve_cnt} + 4'd1) == {1'b0, LIMIT});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode       <= NORMAL;
            r_starve_cnt <= '0;
            r_vid_rvalid <= 1'b0;
        end else begin
            r_vid_rvalid <= w_vid_gnt;
            r_starve_cnt <= w_starved ? w_cnt_inc : '0;
            case (r_mode)
                NORMAL:  r_mode <= w_force_next ? FORCE : NORMAL;
                FORCE:   r_mode <= NORMAL;
                default: r_mode <= NORMAL;
            endcase
        end
    end

    assign vid_gnt     = w_vid_gnt;
    assign cpu_stall   = cpu_req && w_vid_gnt;
    assign mem_address = w_vid_gnt ? vid_address : cpu_address;
    assign mem_data    = cpu_data;
    assign mem_wren    = cpu_req && cpu_wren && !w_vid_gnt && !reset;
    assign vid_rvalid  = r_vid_rvalid;
    assign cpu_q       = mem_q;
    assign vid_q       = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a one-cycle-latency dmem model.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic [11:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic        cpu_stall;
    logic [31:0] cpu_q;
    logic        vid_req;
    logic [11:0] vid_address;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [31:0] vid_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_wren    (cpu_wren),
        .cpu_stall   (cpu_stall),
        .cpu_q       (cpu_q),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_gnt     (vid_gnt),
        .vid_rvalid  (vid_rvalid),
        .vid_q       (vid_q),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Unwritten words read as 0xA0000000 | address.
    logic [31:0] wmem [4096];
    bit   [4095:0] wr_valid;
    int          wr_cnt_030 = 0;

    always @(posedge clock) begin
        if (mem_wren) begin
            wmem[mem_address]     <= mem_data;
            wr_valid[mem_address] <= 1'b1;
            if (mem_address == 12'h030) wr_cnt_030 <= wr_cnt_030 + 1;
        end
        mem_q <= wr_valid[mem_address] ? wmem[mem_address]
                                       : (32'hA000_0000 | {20'h0, mem_address});
    end

    typedef struct {
        logic        rst, creq, cw;
        logic [11:0] caddr;
        logic [31:0] cdata;
        logic        vreq;
        logic [11:0] vaddr;
        logic        gnt, stall, wren, rv;
        bit          chk_vq;
        logic [31:0] vq;
        bit          chk_cq;
        logic [31:0] cq;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic creq, input logic cw,
                       input logic [11:0] caddr, input logic [31:0] cdata,
                       input logic vreq, input logic [11:0] vaddr,
                       input logic gnt, input logic stall, input logic wren, input logic rv);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cw = cw; v.caddr = caddr; v.cdata = cdata;
        v.vreq = vreq; v.vaddr = vaddr;
        v.gnt = gnt; v.stall = stall; v.wren = wren; v.rv = rv;
        v.chk_vq = 0; v.vq = '0; v.chk_cq = 0; v.cq = '0;
        vecs.push_back(v);
    endtask

    task automatic add_vq(input logic [31:0] d);
        vec_t v;
        v = vecs.pop_back();
        v.chk_vq = 1; v.vq = d;
        vecs.push_back(v);
    endtask

    task automatic add_cq(input logic [31:0] d);
        vec_t v;
        v = vecs.pop_back();
        v.chk_cq = 1; v.cq = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cpu_req = 0; cpu_wren = 0; cpu_address = '0; cpu_data = '0;
        vid_req = 0; vid_address = '0;

        //   rst creq cw caddr   cdata          vreq vaddr   gnt stall wren rv
        add(1, 1, 1, 12'h010, 32'hDEADBEEF, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 1, 12'h010, 32'hDEADBEEF, 0, 12'h200, 0, 0, 1, 0);
        // Continuous contention: forced grant every fifth cycle
        for (int k = 0; k < 4; k++) add(0, 1, 0, 12'h020, 0, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 0, 12'h020, 0, 1, 12'h200, 1, 1, 0, 0);
        add(0, 1, 0, 12'h020, 0, 1, 12'h200, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 12'h020, 0, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 0, 12'h020, 0, 1, 12'h200, 1, 1, 0, 0);
        add(0, 1, 0, 12'h020, 0, 1, 12'h200, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 12'h020, 0, 1, 12'h200, 0, 0, 0, 0);
        // Stalled write on forced cycle, retried next cycle
        add(0, 1, 1, 12'h030, 32'h12345678, 1, 12'h200, 1, 1, 0, 0);
        add(0, 1, 1, 12'h030, 32'h12345678, 0, 12'h200, 0, 0, 1, 1);
        // FORCE entered, video drops the request in the forced cycle
        for (int k = 0; k < 4; k++) add(0, 1, 0, 12'h040, 0, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 1, 12'h050, 32'hCAFEF00D, 0, 12'h200, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 12'h040, 0, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 0, 12'h040, 0, 1, 12'h200, 1, 1, 0, 0);
        add(0, 0, 1, 12'h060, 32'h0BAD0BAD, 0, 12'h200, 0, 0, 0, 1);
        // Reset the cycle after a video grant
        add(0, 0, 0, 12'h070, 0, 1, 12'h200, 1, 0, 0, 0);
        add(1, 1, 0, 12'h070, 0, 1, 12'h200, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 12'h070, 0, 1, 12'h200, 0, 0, 0, 0);
        add(0, 1, 0, 12'h070, 0, 1, 12'h200, 1, 1, 0, 0);
        // Back-to-back video reads 0x100..0x103
        add(0, 0, 0, 12'h070, 0, 1, 12'h100, 1, 0, 0, 1); add_vq(32'hA0000200);
        add(0, 0, 0, 12'h070, 0, 1, 12'h101, 1, 0, 0, 1); add_vq(32'hA0000100);
        add(0, 0, 0, 12'h070, 0, 1, 12'h102, 1, 0, 0, 1); add_vq(32'hA0000101);
        add(0, 0, 0, 12'h070, 0, 1, 12'h103, 1, 0, 0, 1); add_vq(32'hA0000102);
        add(0, 0, 0, 12'h070, 0, 0, 12'h200, 0, 0, 0, 1); add_vq(32'hA0000103);
        // CPU reads back its first write
        add(0, 1, 0, 12'h010, 0, 0, 12'h200, 0, 0, 0, 0);
        add(0, 0, 0, 12'h070, 0, 0, 12'h200, 0, 0, 0, 0); add_cq(32'hDEADBEEF);

        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [11:0] e_addr;
            v = vecs[i];
            @(posedge clock);
            #1;
            reset = v.rst; cpu_req = v.creq; cpu_wren = v.cw; cpu_address = v.caddr;
            cpu_data = v.cdata; vid_req = v.vreq; vid_address = v.vaddr;
            #2;
            e_addr = v.gnt ? v.vaddr : v.caddr;
            check($sformatf("v%0d vid_gnt", i),     {31'b0, vid_gnt},    {31'b0, v.gnt});
            check($sformatf("v%0d cpu_stall", i),   {31'b0, cpu_stall},  {31'b0, v.stall});
            check($sformatf("v%0d mem_wren", i),    {31'b0, mem_wren},   {31'b0, v.wren});
            check($sformatf("v%0d vid_rvalid", i),  {31'b0, vid_rvalid}, {31'b0, v.rv});
            check($sformatf("v%0d mem_address", i), {20'b0, mem_address}, {20'b0, e_addr});
            if (!v.gnt) check($sformatf("v%0d mem_data", i), mem_data, v.cdata);
            if (v.chk_vq) check($sformatf("v%0d vid_q", i), vid_q, v.vq);
            if (v.chk_cq) check($sformatf("v%0d cpu_q", i), cpu_q, v.cq);
        end

        @(posedge clock);
        #1;
        check("write 0x030 count", wr_cnt_030, 1);
        check("dmem[0x030]", wmem[12'h030], 32'h12345678);
        check("dmem[0x050]", wmem[12'h050], 32'hCAFEF00D);
        check("dmem[0x060] untouched", {31'b0, wr_valid[12'h060]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
